alu_cmd_sequencer: RTL

Command-side initiator for the signed 16-bit ALU. It accepts operation requests over a valid/ready command channel and drives operands and `ALU_FUN` into the ALU. It then waits for the flag of the enabled unit, selects and widens that unit's registered result, and returns it over a valid/ready response channel. It also provides a timeout error path. It sits between a host or controller and the ALU top, and is the only driver of the ALU's `A`, `B` and `ALU_FUN` inputs.

---
 rtl/alu_cmd_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command-side ALU initiator: cmd handshake -> drive alu_* -> wait unit flag -> rsp; 3-cycle latency, held until rsp_ready.
// ALU_SEQ_SKID_EN adds a one-entry command buffer so a new command can be taken during WAIT/RESP.
module alu_cmd_sequencer #(
  parameter int IN_DATA_WIDTH   = 16,
  parameter int ARITH_OUT_WIDTH = 32,
  parameter int LOGIC_OUT_WIDTH = 16,
  parameter int SHIFT_OUT_WIDTH = 16,
  parameter int CMP_OUT_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES  = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_fun,
  input  logic [IN_DATA_WIDTH-1:0]   cmd_a,
  input  logic [IN_DATA_WIDTH-1:0]   cmd_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ARITH_OUT_WIDTH-1:0] rsp_data,
  output logic [3:0]                 rsp_fun,
  output logic                       rsp_err,
  output logic [IN_DATA_WIDTH-1:0]   alu_a,
  output logic [IN_DATA_WIDTH-1:0]   alu_b,
  output logic [3:0]                 alu_fun,
  input  logic [ARITH_OUT_WIDTH-1:0] alu_arith_out,
  input  logic [LOGIC_OUT_WIDTH-1:0] alu_logic_out,
  input  logic [SHIFT_OUT_WIDTH-1:0] alu_shift_out,
  input  logic [CMP_OUT_WIDTH-1:0]   alu_cmp_out,
  input  logic                       alu_arith_flag,
  input  logic                       alu_logic_flag,
  input  logic                       alu_cmp_flag,
  input  logic                       alu_shift_flag
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic                       flag_hit;
  logic [ARITH_OUT_WIDTH-1:0] sel_data;
  logic                       cmd_fire;
  logic                       rsp_fire;

`ifdef ALU_SEQ_SKID_EN
  logic                     buf_vld;
  logic [3:0]               buf_fun;
  logic [IN_DATA_WIDTH-1:0] buf_a;
  logic [IN_DATA_WIDTH-1:0] buf_b;

  assign cmd_ready = !RST && ((state == IDLE) || !buf_vld);
`else
  assign cmd_ready = !RST && (state == IDLE);
`endif

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // Only the unit addressed by alu_fun[3:2] may complete the command.
  always_comb begin
    flag_hit = 1'b0;
    sel_data = '0;
    case (alu_fun[3:2])
      2'b00: begin flag_hit = alu_arith_flag; sel_data = alu_arith_out; end
      2'b01: begin flag_hit = alu_logic_flag; sel_data = ARITH_OUT_WIDTH'(alu_logic_out); end
      2'b10: begin flag_hit = alu_cmp_flag;   sel_data = ARITH_OUT_WIDTH'(alu_cmp_out); end
      default: begin flag_hit = alu_shift_flag; sel_data = ARITH_OUT_WIDTH'(alu_shift_out); end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fun   <= '0;
      rsp_err   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= '0;
`ifdef ALU_SEQ_SKID_EN
      buf_vld   <= 1'b0;
      buf_fun   <= '0;
      buf_a     <= '0;
      buf_b     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_fun <= cmd_fun;
            cnt     <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // A flag on the terminal-count cycle still beats the timeout.
          if (flag_hit) begin
            rsp_data  <= sel_data;
            rsp_err   <= 1'b0;
            rsp_fun   <= alu_fun;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_fun   <= alu_fun;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid <= 1'b0;
`ifdef ALU_SEQ_SKID_EN
            if (buf_vld) begin
              alu_a   <= buf_a;
              alu_b   <= buf_b;
              alu_fun <= buf_fun;
              buf_vld <= 1'b0;
              cnt     <= '0;
              state   <= WAIT;
            end else if (cmd_fire) begin
              alu_a   <= cmd_a;
              alu_b   <= cmd_b;
              alu_fun <= cmd_fun;
              cnt     <= '0;
              state   <= WAIT;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
`ifdef ALU_SEQ_SKID_EN
      // Commands taken while busy park here unless they go straight to the ALU.
      if (cmd_fire && (state != IDLE) && !((state == RESP) && rsp_fire)) begin
        buf_vld <= 1'b1;
        buf_fun <= cmd_fun;
        buf_a   <= cmd_a;
        buf_b   <= cmd_b;
      end
`endif
    end
  end

endmodule
